// File: rtl/dm_arb_defs.sv
// Shared definitions for the data-memory arbiter: FSM state and owner
// encodings plus default address/data widths.
package dm_arb_defs;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  localparam logic OWN_M0 = 1'b0;
  localparam logic OWN_M1 = 1'b1;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/rr_pick2.sv
// Two-way combinational picker. Round-robin on the last winner by default;
// DM_ARB_FIXED_PRIO_EN selects fixed priority with requester 0 always first.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       win,
  output logic       valid
);
  import dm_arb_defs::*;

`ifdef DM_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last;
`endif

  // Choose the winner from the current requests
  always_comb begin
    valid = |req;
`ifdef DM_ARB_FIXED_PRIO_EN
    win = req[0] ? OWN_M0 : OWN_M1;
`else
    if (req == 2'b11) begin
      win = ~last;
    end else begin
      win = req[0] ? OWN_M0 : OWN_M1;
    end
`endif
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of the single-ported data memory.
// One access per two cycles: IDLE arbitrates and latches, ACCESS drives the
// memory, read data is registered back to the owner on leaving ACCESS.
// Build option: DM_ARB_FIXED_PRIO_EN gives m0 fixed priority over m1.
module dm_arbiter
  import dm_arb_defs::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout
);

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                m0_gnt_q, m0_gnt_d, m1_gnt_q, m1_gnt_d;
  logic                mem_we_q, mem_we_d;
  logic                m0_rvalid_q, m0_rvalid_d, m1_rvalid_q, m1_rvalid_d;
  logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic                last_q, last_d;
  logic                pick_win, pick_valid;

  rr_pick2 u_pick (
    .req   ({m1_req, m0_req}),
    .last  (last_q),
    .win   (pick_win),
    .valid (pick_valid)
  );

  // Next-state, latch and response logic for the IDLE/ACCESS sequence
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    last_d      = last_q;
    m0_gnt_d    = 1'b0;
    m1_gnt_d    = 1'b0;
    mem_we_d    = 1'b0;
    m0_rvalid_d = 1'b0;
    m1_rvalid_d = 1'b0;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_ACCESS;
          owner_d = pick_win;
          if (pick_win == OWN_M1) begin
            we_d     = m1_we;
            addr_d   = m1_addr;
            wdata_d  = m1_wdata;
            m1_gnt_d = 1'b1;
          end else begin
            we_d     = m0_we;
            addr_d   = m0_addr;
            wdata_d  = m0_wdata;
            m0_gnt_d = 1'b1;
          end
          mem_we_d = we_d;
`ifndef DM_ARB_FIXED_PRIO_EN
          last_d = pick_win;
`endif
        end
      end
      ST_ACCESS: begin
        state_d = ST_IDLE;
        if (!we_q) begin
          if (owner_q == OWN_M1) begin
            m1_rvalid_d = 1'b1;
            m1_rdata_d  = mem_dout;
          end else begin
            m0_rvalid_d = 1'b1;
            m0_rdata_d  = mem_dout;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any in-flight access
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_M0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      last_q      <= OWN_M1;
      m0_gnt_q    <= 1'b0;
      m1_gnt_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      last_q      <= last_d;
      m0_gnt_q    <= m0_gnt_d;
      m1_gnt_q    <= m1_gnt_d;
      mem_we_q    <= mem_we_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  assign m0_gnt    = m0_gnt_q;
  assign m1_gnt    = m1_gnt_q;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign mem_addr  = addr_q;
  assign mem_din   = wdata_q;
  assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Randomised and directed bench for dm_arbiter with a cycle scoreboard.
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [9:0]  m0_addr = '0;
  logic [31:0] m0_wdata = '0;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [9:0]  m1_addr = '0;
  logic [31:0] m1_wdata = '0;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_we;
  logic [31:0] m0_rdata, m1_rdata, mem_din, mem_dout;
  logic [9:0]  mem_addr;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  dm_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Memory the arbiter drives: combinational read, write on the edge
  logic [31:0] mem [0:1023];
  initial for (int i = 0; i < 1024; i++) mem[i] = '0;
  assign mem_dout = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_din;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: accesses happen in grant order on a private memory copy
  logic [31:0] ref_mem [0:1023];
  initial for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
  bit          m_busy = 0, m_last = 1;
  bit          cur_own = 0, cur_we = 0;
  logic [9:0]  cur_addr = '0;
  logic [31:0] cur_data = '0;
  logic [1:0]  e_gnt = '0, e_rv = '0;
  bit          e_we = 0;
  logic [9:0]  e_addr = '0;
  logic [31:0] e_din = '0, e_rd0 = '0, e_rd1 = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 0; m_last = 1; e_gnt = '0; e_rv = '0; e_we = 0;
      e_addr = '0; e_din = '0; e_rd0 = '0; e_rd1 = '0;
    end else begin
      e_rv = '0;
      if (m_busy) begin
        m_busy = 0; e_gnt = '0; e_we = 0;
        if (cur_we) ref_mem[cur_addr] = cur_data;
        else begin
          e_rv[cur_own] = 1'b1;
          if (cur_own) e_rd1 = ref_mem[cur_addr]; else e_rd0 = ref_mem[cur_addr];
        end
      end else if (m0_req || m1_req) begin
        if (m0_req && m1_req) begin
`ifdef DM_ARB_FIXED_PRIO_EN
          cur_own = 0;
`else
          cur_own = !m_last;
`endif
        end else cur_own = m1_req;
`ifndef DM_ARB_FIXED_PRIO_EN
        m_last = cur_own;
`endif
        cur_we   = cur_own ? m1_we : m0_we;
        cur_addr = cur_own ? m1_addr : m0_addr;
        cur_data = cur_own ? m1_wdata : m0_wdata;
        m_busy = 1;
        e_gnt = '0; e_gnt[cur_own] = 1'b1;
        e_we = cur_we; e_addr = cur_addr; e_din = cur_data;
      end
    end
  end

  // Compare every output against the model mid-cycle
  always @(negedge clk) if (chk_en) begin
    check("m0_gnt", 32'(m0_gnt), 32'(e_gnt[0]));
    check("m1_gnt", 32'(m1_gnt), 32'(e_gnt[1]));
    check("mem_we", 32'(mem_we), 32'(e_we));
    check("mem_addr", 32'(mem_addr), 32'(e_addr));
    check("mem_din", mem_din, e_din);
    check("m0_rvalid", 32'(m0_rvalid), 32'(e_rv[0]));
    check("m1_rvalid", 32'(m1_rvalid), 32'(e_rv[1]));
    check("m0_rdata", m0_rdata, e_rd0);
    check("m1_rdata", m1_rdata, e_rd1);
  end

  // Present one request (entered just after a rising edge) and hold until granted
  task automatic do_req(input int p, input logic we, input logic [9:0] a, input logic [31:0] d);
    int n = 0;
    bit got = 0;
    if (p == 0) begin m0_req = 1; m0_we = we; m0_addr = a; m0_wdata = d; end
    else        begin m1_req = 1; m1_we = we; m1_addr = a; m1_wdata = d; end
    while (!got && n < 20) begin
      @(posedge clk); #1;
      n++;
      got = (p == 0) ? m0_gnt : m1_gnt;
    end
    if (p == 0) m0_req = 0; else m1_req = 0;
    if (!got) check("gnt_timeout", 32'(got), 32'd1);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic rand_port(input int p);
    logic [9:0] a;
    tick($urandom_range(0, 3));
    a = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 7));
    do_req(p, 1'($urandom_range(0, 1)), a, $urandom);
  endtask

  int g0, g1;

  initial begin
    tick(3);
    reset_n = 1;
    chk_en = 1;
    tick(1);

    // Reset state of outputs
    check("rst_m0_rdata", m0_rdata, 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);

    // m0 write, then read back
    do_req(0, 1, 10'h005, 32'hDEADBEEF);
    check("wr_mem_addr", 32'(mem_addr), 32'h005);
    check("wr_mem_we", 32'(mem_we), 32'd1);
    tick(1);
    check("wr_no_rvalid", 32'(m0_rvalid), 32'd0);
    do_req(0, 0, 10'h005, 32'h0);
    tick(1);
    check("rd_rvalid", 32'(m0_rvalid), 32'd1);
    check("rd_rdata", m0_rdata, 32'hDEADBEEF);
    tick(2);
    check("rd_rdata_hold", m0_rdata, 32'hDEADBEEF);

    // Continuous contention for 8 cycles
    m0_req = 1; m0_we = 0; m0_addr = 10'h001;
    m1_req = 1; m1_we = 0; m1_addr = 10'h002;
    g0 = 0; g1 = 0;
    repeat (8) begin tick(1); g0 += int'(m0_gnt); g1 += int'(m1_gnt); end
    m0_req = 0; m1_req = 0;
`ifdef DM_ARB_FIXED_PRIO_EN
    check("contend_m0", 32'(g0), 32'd4);
    check("contend_m1", 32'(g1), 32'd0);
`else
    check("contend_m0", 32'(g0), 32'd2);
    check("contend_m1", 32'(g1), 32'd2);
`endif
    tick(2);

    // m1 write top address, m0 read it right behind
    do_req(1, 1, 10'h3FF, 32'h12345678);
    do_req(0, 0, 10'h3FF, 32'h0);
    tick(1);
    check("raw_rdata", m0_rdata, 32'h12345678);
    tick(2);

    // Reset pulse in the middle of an m1 write access
    m1_req = 1; m1_we = 1; m1_addr = 10'h3FF; m1_wdata = 32'hCAFEF00D;
    tick(1);
    m1_req = 0;
    check("pre_rst_gnt", 32'(m1_gnt), 32'd1);
    #1 reset_n = 0;
    #1;
    check("async_mem_we", 32'(mem_we), 32'd0);
    check("async_m1_gnt", 32'(m1_gnt), 32'd0);
    @(negedge clk);
    reset_n = 1;
    tick(1);
    check("lost_write", mem[10'h3FF], 32'h12345678);
    check("post_rst_rdata", m0_rdata, 32'd0);
    m0_req = 1; m0_we = 0; m0_addr = 10'h004;
    m1_req = 1; m1_we = 0; m1_addr = 10'h005;
    tick(1);
    m0_req = 0; m1_req = 0;
    check("post_rst_m0_win", 32'(m0_gnt), 32'd1);
    tick(3);

    // One-cycle request yields exactly one grant
    m0_req = 1; m0_we = 0; m0_addr = 10'h005;
    tick(1);
    m0_req = 0;
    g0 = int'(m0_gnt);
    repeat (5) begin tick(1); g0 += int'(m0_gnt); end
    check("single_gnt", 32'(g0), 32'd1);

    // Randomised traffic on both ports
    for (int k = 0; k < 60; k++) begin
      fork
        rand_port(0);
        rand_port(1);
      join
    end
    tick(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
